// File: rtl/branch_check_if.sv
// ============================================================================
//  Module      : branch_check_if
//  Description : Bundles the pipeline-facing signals of branch_check. The
//                pipeline side drives the D-stage branch info, the stalls
//                and the flushes, and reads the M-stage resolution results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_check_if #(
  parameter int CNT_W = 32
);
  // Pipeline control
  logic             stallE;
  logic             stallM;
  logic             flushE;
  logic             flushM;
  // D-stage branch information from the predictor
  logic             branchD;
  logic             pred_takeD;
  logic [31:0]      pcD;
  logic [31:0]      targetD;
  // M-stage resolved direction
  logic             actual_takeM;
  // M-stage results and predictor feedback
  logic             branchM;
  logic [31:0]      pcM;
  logic             pred_takeM;
  logic             mispredictM;
  logic [31:0]      redirect_pcM;
  logic             flush_req;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Pipeline / predictor side
  modport master (
    output stallE, stallM, flushE, flushM,
    output branchD, pred_takeD, pcD, targetD, actual_takeM,
    input  branchM, pcM, pred_takeM, mispredictM, redirect_pcM, flush_req,
    input  branch_cnt, mispred_cnt
  );

  // branch_check side
  modport slave (
    input  stallE, stallM, flushE, flushM,
    input  branchD, pred_takeD, pcD, targetD, actual_takeM,
    output branchM, pcM, pred_takeM, mispredictM, redirect_pcM, flush_req,
    output branch_cnt, mispred_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_check.sv
// ============================================================================
//  Module      : branch_check
//  Description : Carries a branch's prediction and target from D through E
//                into M, resolves it against the actual direction at M,
//                raises mispredict/flush, produces the redirect PC, feeds
//                the predictor update and keeps saturating statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_check #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  branch_check_if.slave bus
);

  // Fall-through distance: skip the delay slot when the ISA has one.
  localparam logic [31:0]      FALL_OFFSET = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // E-stage branch record
  logic        valid_e;
  logic        pred_e;
  logic [31:0] pc_e;
  logic [31:0] target_e;

  // M-stage branch record
  logic        valid_m;
  logic        pred_m;
  logic [31:0] pc_m;
  logic [31:0] target_m;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic        mispredict;
  logic        retire;

  assign mispredict = valid_m & (pred_m != bus.actual_takeM);
  // A branch is counted on the cycle it leaves M, so a stall never double-counts.
  assign retire     = valid_m & ~bus.stallM;

  assign bus.branchM      = valid_m;
  assign bus.pcM          = pc_m;
  assign bus.pred_takeM   = pred_m;
  assign bus.mispredictM  = mispredict;
  assign bus.flush_req    = mispredict;
  // Predicted taken but fell through -> sequential PC; predicted not-taken but taken -> target.
  assign bus.redirect_pcM = pred_m ? (pc_m + FALL_OFFSET) : target_m;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;

  // E register: a mispredict in M squashes whatever would enter E, even over a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e  <= 1'b0;
      pred_e   <= 1'b0;
      pc_e     <= 32'd0;
      target_e <= 32'd0;
    end else if (bus.flushE || mispredict) begin
      valid_e  <= 1'b0;
    end else if (!bus.stallE) begin
      valid_e  <= bus.branchD;
      pred_e   <= bus.pred_takeD;
      pc_e     <= bus.pcD;
      target_e <= bus.targetD;
    end
  end

  // M register: takes the E record (bubble included) unless flushed or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m  <= 1'b0;
      pred_m   <= 1'b0;
      pc_m     <= 32'd0;
      target_m <= 32'd0;
    end else if (bus.flushM) begin
      valid_m  <= 1'b0;
    end else if (!bus.stallM) begin
      valid_m  <= valid_e;
      pred_m   <= pred_e;
      pc_m     <= pc_e;
      target_m <= target_e;
    end
  end

  // Saturating statistics, stepped once per branch leaving M.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (retire) begin
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      end
      if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_check.sv
// ============================================================================
//  Module      : tb_branch_check
//  Description : Self-checking bench for branch_check: directed vector table,
//                hand-written stall / reset / saturation sequences and a
//                randomized run against a behavioural pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_check;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_check_if #(.CNT_W(CNT_W)) bus ();

  branch_check #(
    .DELAY_SLOT (1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one record per pipeline slot, plus plain integer counters.
  typedef struct packed {
    logic        v;
    logic        p;
    logic [31:0] pc;
    logic [31:0] tg;
  } slot_t;

  slot_t me;
  slot_t mm;
  int    bc;
  int    mc;

  typedef struct {
    logic        sE, sM, fE, fM, bD, pD;
    logic [31:0] pc, tg;
    logic        act;
    logic        exp_bm, exp_mis;
    logic [31:0] exp_rd;
    int          exp_bc, exp_mc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    me = '0;
    mm = '0;
    bc = 0;
    mc = 0;
  endtask

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic drive(input logic sE, input logic sM, input logic fE, input logic fM,
                       input logic bD, input logic pD, input logic [31:0] pc,
                       input logic [31:0] tg, input logic act);
    bus.stallE       = sE;
    bus.stallM       = sM;
    bus.flushE       = fE;
    bus.flushM       = fM;
    bus.branchD      = bD;
    bus.pred_takeD   = pD;
    bus.pcD          = pc;
    bus.targetD      = tg;
    bus.actual_takeM = act;
  endtask

  // One clock cycle, entered and left at a falling edge; checks against the model.
  task automatic cycle(input logic sE, input logic sM, input logic fE, input logic fM,
                       input logic bD, input logic pD, input logic [31:0] pc,
                       input logic [31:0] tg, input logic act);
    logic mis;
    drive(sE, sM, fE, fM, bD, pD, pc, tg, act);
    #1;
    mis = mm.v && (mm.p != act);
    chk("branchM",     32'(bus.branchM),     32'(mm.v));
    chk("mispredictM", 32'(bus.mispredictM), 32'(mis));
    chk("flush_req",   32'(bus.flush_req),   32'(mis));
    chk("branch_cnt",  32'(bus.branch_cnt),  32'(bc));
    chk("mispred_cnt", 32'(bus.mispred_cnt), 32'(mc));
    if (mm.v) begin
      chk("pcM",          bus.pcM,               mm.pc);
      chk("pred_takeM",   32'(bus.pred_takeM),   32'(mm.p));
      chk("redirect_pcM", bus.redirect_pcM,      mm.p ? (mm.pc + 32'd8) : mm.tg);
    end
    @(posedge clk);
    if (mm.v && !sM) begin
      bc = sat(bc);
      if (mis) mc = sat(mc);
    end
    if (fM)       mm.v = 1'b0;
    else if (!sM) mm   = me;
    if (fE || mis)  me.v = 1'b0;
    else if (!sE)   me   = '{bD, pD, pc, tg};
    @(negedge clk);
  endtask

  task automatic idle(input logic act);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, act);
  endtask

  // Reset asserted mid-cycle (not on an edge): outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_branchM",     32'(bus.branchM),     32'd0);
    chk("rst_mispredictM", 32'(bus.mispredictM), 32'd0);
    chk("rst_flush_req",   32'(bus.flush_req),   32'd0);
    chk("rst_pcM",         bus.pcM,              32'd0);
    chk("rst_pred_takeM",  32'(bus.pred_takeM),  32'd0);
    chk("rst_redirect",    bus.redirect_pcM,     32'd0);
    chk("rst_branch_cnt",  32'(bus.branch_cnt),  32'd0);
    chk("rst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            sE sM fE fM bD pD pcD           targetD      act  bm mis redirect     bc mc
    tbl[0]  = '{0, 0, 0, 0, 1, 0, 32'h100,      32'h200,     0,   0, 0,  32'h0,       0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   0, 0,  32'h0,       0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       1,   1, 1,  32'h200,     0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 1, 32'h100,      32'h300,     0,   0, 0,  32'h0,       1, 1};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 32'h400,      32'h500,     0,   0, 0,  32'h0,       1, 1};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 32'h600,      32'h700,     0,   1, 1,  32'h108,     1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   1, 0,  32'h500,     2, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   0, 0,  32'h0,       3, 2};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h10,      0,   0, 0,  32'h0,       3, 2};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   0, 0,  32'h0,       3, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   1, 1,  32'h4,       3, 2};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,       0,   0, 0,  32'h0,       4, 3};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    model_reset();
    @(negedge clk);
    async_reset();

    // Directed vectors: taken mispredict, not-taken mispredict with squash, PC wrap.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].sE, tbl[i].sM, tbl[i].fE, tbl[i].fM, tbl[i].bD, tbl[i].pD,
            tbl[i].pc, tbl[i].tg, tbl[i].act);
      #1;
      chk($sformatf("tbl%0d_branchM", i),     32'(bus.branchM),     32'(tbl[i].exp_bm));
      chk($sformatf("tbl%0d_mispredict", i),  32'(bus.mispredictM), 32'(tbl[i].exp_mis));
      chk($sformatf("tbl%0d_branch_cnt", i),  32'(bus.branch_cnt),  32'(tbl[i].exp_bc));
      chk($sformatf("tbl%0d_mispred_cnt", i), 32'(bus.mispred_cnt), 32'(tbl[i].exp_mc));
      if (tbl[i].exp_bm) chk($sformatf("tbl%0d_redirect", i), bus.redirect_pcM, tbl[i].exp_rd);
      cycle(tbl[i].sE, tbl[i].sM, tbl[i].fE, tbl[i].fM, tbl[i].bD, tbl[i].pD,
            tbl[i].pc, tbl[i].tg, tbl[i].act);
    end

    // Branches in both E and M, then reset in the middle of the cycle.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'h3000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    1'b1);
    async_reset();

    // Correctly predicted branch held in M by a 3-cycle stall.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h80, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      chk("stall_branch_cnt_held", 32'(bus.branch_cnt), 32'd0);
    end
    idle(1'b1);
    chk("stall_branch_cnt_release", 32'(bus.branch_cnt), 32'd1);
    chk("stall_mispred_cnt",        32'(bus.mispred_cnt), 32'd0);

    // Saturation: a long stream of mispredicted branches.
    async_reset();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h8000, 1'b1);
    end
    chk("sat_branch_cnt",  32'(bus.branch_cnt),  32'hF);
    chk("sat_mispred_cnt", 32'(bus.mispred_cnt), 32'hF);

    // Randomized traffic against the model, with a reset part-way through.
    async_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cycle(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 10) == 0,
            ($urandom % 10) == 0, 1'($urandom), 1'($urandom),
            {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
